// File: rtl/oit_shift_add_multiplier.sv
// ============================================================================
//  Module   : oit_shift_add_multiplier
//  Brief    : Sequential unsigned shift-and-add multiplier, one multiplier bit
//             per clock, with start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Plain modular adder; the carry-out is dropped because the product always fits.
module oit_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum
);

  assign sum = x + y;

endmodule

module oit_shift_add_multiplier #(
  parameter int WIDTH_a = 8,
  parameter int WIDTH_b = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH_a-1:0]         a,
  input  logic [WIDTH_b-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH_a+WIDTH_b-1:0] product
);

  localparam int c_PROD_W = WIDTH_a + WIDTH_b;
  localparam int c_CNT_W  = (WIDTH_b > 1) ? $clog2(WIDTH_b) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH_b - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_PROD_W-1:0]   r_mcand;
  logic [c_PROD_W-1:0]   r_acc;
  logic [c_PROD_W-1:0]   w_sum;
  logic [c_PROD_W-1:0]   w_acc_next;
  logic [WIDTH_b-1:0]    r_mplier;
  logic [c_CNT_W-1:0]    r_count;
  logic                  w_load;
  logic                  w_step;
  logic                  w_last;

  oit_adder #(
    .WIDTH (c_PROD_W)
  ) u_adder (
    .x   (r_acc),
    .y   (r_mcand),
    .sum (w_sum)
  );

  assign w_acc_next = r_mplier[0] ? w_sum : r_acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_count == c_LAST) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Fixed latency: all WIDTH_b iterations run even once the multiplier is zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_load) begin
      r_mcand  <= {{WIDTH_b{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_step) begin
      r_mcand  <= {r_mcand[c_PROD_W-2:0], 1'b0};
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_next;
      r_count  <= r_count + 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= (w_state_next == RUN);
      done <= (w_state_next == DONE);
      if (w_last) begin
        product <= w_acc_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oit_shift_add_multiplier.sv
// ============================================================================
//  Module   : tb_oit_shift_add_multiplier
//  Brief    : Directed self-checking bench for oit_shift_add_multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oit_shift_add_multiplier;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  logic        start2;
  logic [3:0]  a2;
  logic [2:0]  b2;
  logic        busy2;
  logic        done2;
  logic [6:0]  product2;

  int total;
  int bad;

  oit_shift_add_multiplier #(
    .WIDTH_a (8),
    .WIDTH_b (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  oit_shift_add_multiplier #(
    .WIDTH_a (4),
    .WIDTH_b (3)
  ) dut_small (
    .clock   (clock),
    .reset   (reset),
    .start   (start2),
    .a       (a2),
    .b       (b2),
    .busy    (busy2),
    .done    (done2),
    .product (product2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full multiply on the 8x8 instance, checking the cadence cycle by cycle.
  task automatic run_mul(input logic [7:0] ai, input logic [7:0] bi, input logic [15:0] exp);
    a     = ai;
    b     = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      tick();
    end
    check("busy_done", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("product", 32'(product), 32'(exp));
    tick();
    check("done_clear", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("product_hold", 32'(product), 32'(exp));
  endtask

  initial begin
    logic [7:0]  acc_a [3];
    logic [7:0]  acc_b [3];
    logic [15:0] acc_p [3];
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start2 = 1'b0;
    a2     = '0;
    b2     = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_product_small", 32'(product2), 32'd0);
    #2 reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Basic, maximum operands, and zero operands.
    run_mul(8'd13, 8'd11, 16'd143);
    run_mul(8'd255, 8'd255, 16'hFE01);
    run_mul(8'd0, 8'd200, 16'd0);
    run_mul(8'd77, 8'd0, 16'd0);

    // start held high; only the IDLE edges (every 10 cycles) are accepted.
    acc_a = '{8'd17, 8'd200, 8'd255};
    acc_b = '{8'd19, 8'd3, 8'd2};
    acc_p = '{16'd323, 16'd600, 16'd510};
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c % 10 == 0) begin
        a = acc_a[c / 10];
        b = acc_b[c / 10];
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      tick();
      check("held_busy", 32'(busy), (c % 10 <= 7) ? 32'd1 : 32'd0);
      check("held_done", 32'(done), (c % 10 == 8) ? 32'd1 : 32'd0);
      if (c % 10 == 8) begin
        check("held_product", 32'(product), 32'(acc_p[c / 10]));
      end
      if (c % 10 == 0 && c > 0) begin
        check("held_product_keep", 32'(product), 32'(acc_p[c / 10 - 1]));
      end
    end
    start = 1'b0;
    tick();

    // Abort mid-run with an asynchronous reset.
    run_mul(8'd13, 8'd11, 16'd143);
    a     = 8'd200;
    b     = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_abort_busy", 32'(busy), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    tick();
    check("abort_hold_done", 32'(done), 32'd0);
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_abort_busy", 32'(busy), 32'd0);
      check("post_abort_done", 32'(done), 32'd0);
    end
    run_mul(8'd3, 8'd5, 16'd15);

    // Small configuration: 4x3 bits.
    a2     = 4'd15;
    b2     = 3'd7;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    a2     = 4'd0;
    b2     = 3'd0;
    for (int i = 0; i < 3; i++) begin
      check("small_busy", 32'(busy2), 32'd1);
      check("small_done_low", 32'(done2), 32'd0);
      tick();
    end
    check("small_busy_end", 32'(busy2), 32'd0);
    check("small_done", 32'(done2), 32'd1);
    check("small_product", 32'(product2), 32'd105);
    tick();
    check("small_done_clear", 32'(done2), 32'd0);
    check("small_product_hold", 32'(product2), 32'd105);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
